reply_tx: RTL and testbench
===========================

# reply_tx

Reply frame transmitter for the command SCI link: encodes status events into the 4-byte reply frames (sync EB 90, then length/code bytes) and streams them byte-wise to the UART transmitter over a valid/ready handshake. It is the transmit-side counterpart of the reply-type detector, emitting exactly the three frame types that detector classifies. It sits between the command/status logic that raises reply requests and the byte-level UART TX.

## Interface
Parameters:
- GAP_CYCLES, 16, idle clock cycles inserted after each frame's last byte before the next frame may start (0 = back-to-back)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  1 = new frames may start; 0 = no new frame starts, in-progress frame and gap complete
- req  in  1  single-cycle request strobe
- req_type  in  3  one-hot-or-multi reply select: [0] ACK, [1] ERR, [2] STAT; sampled when req=1
- tx_data  out  8  current frame byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART TX accepts byte when tx_valid & tx_ready
- busy  out  1  1 while not in IDLE
- frame_done  out  1  one-cycle pulse after last byte of a frame is accepted
- drop_cnt  out  8  saturating count of dropped requests

## Operation
- Frames: ACK = EB 90 00 76; ERR = EB 90 04 FF; STAT = EB 90 04 F0; sent byte 0 first.
- Pending flags: one sticky bit per type. req=1 sets the bit for every set bit of req_type; req with req_type=000 is ignored.
- Drop: req for a type whose pending bit is already set (and not being cleared that cycle) is dropped; drop_cnt += number of dropped types, saturating at 255.
- Arbitration priority when several pending: ERR > STAT > ACK.
- FSM states: IDLE, SEND, GAP.
  - IDLE: if en=1 and any pending bit set, select highest-priority type, clear its pending bit, load byte index 0, go SEND.
  - SEND: tx_valid=1, tx_data = byte[idx] of latched type; held stable until handshake. On handshake idx<3: idx+1. On handshake idx=3: pulse frame_done next cycle; go GAP if GAP_CYCLES>0 else IDLE.
  - GAP: down-counter loaded with GAP_CYCLES; returns to IDLE when it reaches 0 after GAP_CYCLES cycles.
- Same-cycle clear and set of one pending bit (IDLE selecting type X while req sets X): bit stays set, no drop — second frame of X queued.
- Latched type is not affected by later requests; a frame is never truncated or altered except by rst.
- en deassertion mid-frame has no effect on that frame.

## Timing
- Reset values: tx_valid=0, tx_data=00, busy=0, frame_done=0, drop_cnt=0, all pending=0, state IDLE, idx=0, gap counter 0.
- rst mid-frame: next cycle tx_valid=0, pending cleared, frame abandoned, no frame_done.
- Latency: req in cycle n -> pending set at n+1 -> tx_valid=1 with byte 0 in cycle n+2 (FSM idle, en=1).
- With tx_ready held 1: bytes in cycles n+2..n+5, frame_done in n+6, GAP cycles n+6..n+5+GAP_CYCLES, next frame tx_valid at n+7+GAP_CYCLES (n+6 if GAP_CYCLES=0 and next pending).
- tx_ready low stalls indefinitely; tx_data/tx_valid unchanged during stall.
- busy=1 from first tx_valid cycle through last GAP cycle.
- All outputs registered.

## Structure
- Package reply_pkg: SYNC0=8'hEB, SYNC1=8'h90; per-type byte constants (ACK 00/76, ERR 04/FF, STAT 04/F0); type index constants ACK=0, ERR=1, STAT=2; FSM state encoding; byte-select function type×idx -> byte.
- One sub-module reply_arb: pending flags, set/clear precedence, drop detection, drop_cnt saturation, priority select. FSM and byte mux in reply_tx.

## Test plan
- Single ACK, tx_ready=1, GAP_CYCLES=16: req at cycle 10 -> bytes EB 90 00 76 in cycles 12–15, frame_done at 16, busy low at 32.
- req_type=111 in one cycle -> frames ERR (EB 90 04 FF), STAT (EB 90 04 F0), ACK (EB 90 00 76) in that order, each separated by 16 idle cycles, drop_cnt=0.
- Backpressure: tx_ready toggles 1,0,0,1 pattern -> each byte held stable while not accepted, frame content unchanged, frame_done only after byte 3 accepted.
- Drop: ERR pending while STAT frame in flight, three further ERR reqs -> one ERR frame sent afterward, drop_cnt=3; 300 drops -> drop_cnt saturates at 255.
- Same-cycle set/clear: ACK req in the IDLE cycle that selects ACK -> two ACK frames, drop_cnt=0.
- rst asserted after byte 1 of an ERR frame with STAT pending -> tx_valid=0 next cycle, no frame_done, no further frames, all outputs at reset values.

Source files
------------

// File: rtl/reply_pkg.sv
// Shared constants, types and byte table for the reply frame transmitter.
package reply_pkg;

  typedef logic [1:0] rtype_t;

  localparam rtype_t TYPE_ACK  = 2'd0;
  localparam rtype_t TYPE_ERR  = 2'd1;
  localparam rtype_t TYPE_STAT = 2'd2;

  localparam logic [7:0] SYNC0     = 8'hEB;
  localparam logic [7:0] SYNC1     = 8'h90;
  localparam logic [7:0] ACK_LEN   = 8'h00;
  localparam logic [7:0] ACK_CODE  = 8'h76;
  localparam logic [7:0] ERR_LEN   = 8'h04;
  localparam logic [7:0] ERR_CODE  = 8'hFF;
  localparam logic [7:0] STAT_LEN  = 8'h04;
  localparam logic [7:0] STAT_CODE = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } tx_state_t;

  function automatic logic [7:0] reply_byte(input rtype_t t, input logic [1:0] idx);
    logic [7:0] b;
    b = '0;
    case (idx)
      2'd0:    b = SYNC0;
      2'd1:    b = SYNC1;
      2'd2:    b = (t == TYPE_ACK) ? ACK_LEN  : (t == TYPE_ERR) ? ERR_LEN  : STAT_LEN;
      default: b = (t == TYPE_ACK) ? ACK_CODE : (t == TYPE_ERR) ? ERR_CODE : STAT_CODE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/reply_arb.sv
// Pending-request flags with drop counting and ERR > STAT > ACK priority select.
module reply_arb
  import reply_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [2:0] req_type,
  input  logic       take,
  output logic       any,
  output rtype_t     sel,
  output logic [7:0] drop_cnt
);

  logic [2:0] pending;
  logic [2:0] set_mask;
  logic [2:0] clr_mask;
  logic [2:0] drop_mask;
  logic [1:0] drop_num;
  logic [8:0] drop_sum;

  always_comb begin
    set_mask  = req ? req_type : '0;
    clr_mask  = take ? (3'b001 << sel) : '0;
    // A set landing on a bit being cleared this cycle re-queues it instead of dropping.
    drop_mask = set_mask & pending & ~clr_mask;
    drop_num  = 2'(drop_mask[0]) + 2'(drop_mask[1]) + 2'(drop_mask[2]);
    drop_sum  = {1'b0, drop_cnt} + 9'(drop_num);
    any       = |pending;
    if (pending[TYPE_ERR])       sel = TYPE_ERR;
    else if (pending[TYPE_STAT]) sel = TYPE_STAT;
    else                         sel = TYPE_ACK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      drop_cnt <= '0;
    end else begin
      pending  <= (pending & ~clr_mask) | set_mask;
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

endmodule

// File: rtl/reply_tx.sv
// Reply frame transmitter: arbitrates pending reply types and streams
// 4-byte frames (EB 90 len code) over a valid/ready byte interface.
module reply_tx
  import reply_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       req,
  input  logic [2:0] req_type,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] drop_cnt
);

  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  tx_state_t     state, state_n;
  logic [1:0]    idx, idx_n;
  rtype_t        cur_type, type_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic          take, any, done_n;
  rtype_t        sel;

  reply_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_type (req_type),
    .take     (take),
    .any      (any),
    .sel      (sel),
    .drop_cnt (drop_cnt)
  );

  always_comb begin
    state_n = state;
    idx_n   = idx;
    type_n  = cur_type;
    gap_n   = gap_cnt;
    take    = 1'b0;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en && any) begin
          take    = 1'b1;
          type_n  = sel;
          idx_n   = '0;
          state_n = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (idx == 2'd3) begin
            done_n = 1'b1;
            if (GAP_CYCLES > 0) begin
              gap_n   = GAP_LOAD;
              state_n = ST_GAP;
            end else if (en && any) begin
              // Without a gap the next frame chains directly so byte 0 follows byte 3.
              take    = 1'b1;
              type_n  = sel;
              idx_n   = '0;
              state_n = ST_SEND;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            idx_n = idx + 2'd1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) state_n = ST_IDLE;
        else               gap_n   = gap_cnt - 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      cur_type   <= TYPE_ACK;
      gap_cnt    <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cur_type   <= type_n;
      gap_cnt    <= gap_n;
      tx_valid   <= (state_n == ST_SEND);
      tx_data    <= (state_n == ST_SEND) ? reply_byte(type_n, idx_n) : '0;
      busy       <= (state_n != ST_IDLE);
      frame_done <= done_n;
    end
  end

endmodule

// File: tb/tb_reply_tx.sv
// Directed self-checking bench for reply_tx with GAP_CYCLES=16.
module tb_reply_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       req = 1'b0;
  logic [2:0] req_type = '0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       busy;
  logic       frame_done;
  logic [7:0] drop_cnt;

  int passes = 0;
  int total  = 0;
  int cyc    = 0;
  bit [3:0] bp_pat = 4'b1001;

  reply_tx #(.GAP_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req        (req),
    .req_type   (req_type),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_req(input logic [2:0] t);
    req = 1'b1;
    req_type = t;
    tick();
    req = 1'b0;
    req_type = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 1'b0;
    req_type = '0;
    en = 1'b1;
    tx_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  // Collects one frame; returns bytes packed byte 0 first and the cycle of byte 0.
  task automatic get_frame(input bit bp, output logic [31:0] f, output int start);
    int k, got, waitc;
    logic [7:0] prev;
    bit stalled;
    k = 0; got = 0; waitc = 0; stalled = 0; prev = '0;
    f = '0;
    start = -1;
    while (!tx_valid && waitc < 200) begin
      tick();
      waitc++;
    end
    if (!tx_valid) begin
      chk("frame_start_timeout", 32'd0, 32'd1);
      return;
    end
    start = cyc;
    while (got < 4 && waitc < 400) begin
      if (bp) tx_ready = bp_pat[k % 4];
      k++;
      if (stalled) begin
        chk("stall_data_hold", {24'd0, tx_data}, {24'd0, prev});
        chk("stall_valid_hold", {31'd0, tx_valid}, 32'd1);
      end
      if (bp) chk("no_early_done", {31'd0, frame_done}, 32'd0);
      if (tx_valid && tx_ready) begin
        f = {f[23:0], tx_data};
        got++;
        stalled = 0;
      end else begin
        stalled = 1;
        prev = tx_data;
      end
      tick();
      waitc++;
    end
    chk("frame_done", {31'd0, frame_done}, 32'd1);
    tx_ready = 1'b1;
  endtask

  initial begin
    logic [31:0] f;
    int s1, s2, s3, nv, nd;

    // Reset values
    tick();
    tick();
    chk("rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    // Single ACK with exact cycle timing (n = request cycle)
    send_req(3'b001);
    chk("ack_n1_valid", {31'd0, tx_valid}, 32'd0);
    tick();
    chk("ack_b0", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hEB});
    chk("ack_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("ack_b1", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h90});
    tick();
    chk("ack_b2", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h00});
    tick();
    chk("ack_b3", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h76});
    tick();
    chk("ack_done", {30'd0, frame_done, tx_valid}, {30'd0, 1'b1, 1'b0});
    chk("ack_gap_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("ack_done_pulse", {31'd0, frame_done}, 32'd0);
    repeat (14) tick();
    chk("ack_last_gap_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("ack_idle_busy", {31'd0, busy}, 32'd0);

    // Three types at once: ERR, STAT, ACK in priority order, 21 cycles apart
    send_req(3'b111);
    get_frame(0, f, s1);
    chk("multi_err", f, 32'hEB9004FF);
    get_frame(0, f, s2);
    chk("multi_stat", f, 32'hEB9004F0);
    chk("multi_spacing1", 32'(s2 - s1), 32'd21);
    get_frame(0, f, s3);
    chk("multi_ack", f, 32'hEB900076);
    chk("multi_spacing2", 32'(s3 - s2), 32'd21);
    chk("multi_drop", {24'd0, drop_cnt}, 32'd0);
    wait_idle();

    // Backpressure with 1,0,0,1 ready pattern on a STAT frame
    send_req(3'b100);
    get_frame(1, f, s1);
    chk("bp_stat", f, 32'hEB9004F0);
    wait_idle();

    // Drops: STAT stalled in flight, ERR queued then re-requested three times
    do_reset();
    tx_ready = 1'b0;
    send_req(3'b100);
    repeat (4) send_req(3'b010);
    chk("drop_cnt3", {24'd0, drop_cnt}, 32'd3);
    chk("drop_stall_b0", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hEB});
    tx_ready = 1'b1;
    get_frame(0, f, s1);
    chk("drop_stat_frame", f, 32'hEB9004F0);
    get_frame(0, f, s1);
    chk("drop_err_frame", f, 32'hEB9004FF);
    chk("drop_cnt3_after", {24'd0, drop_cnt}, 32'd3);
    wait_idle();

    // Saturation: ACK held pending with en=0, 300 further ACK requests
    en = 1'b0;
    send_req(3'b001);
    repeat (100) send_req(3'b001);
    chk("drop_cnt103", {24'd0, drop_cnt}, 32'd103);
    chk("en0_no_start", {31'd0, tx_valid}, 32'd0);
    repeat (200) send_req(3'b001);
    chk("drop_sat", {24'd0, drop_cnt}, 32'd255);
    en = 1'b1;
    get_frame(0, f, s1);
    chk("sat_ack_frame", f, 32'hEB900076);
    chk("drop_sat_hold", {24'd0, drop_cnt}, 32'd255);
    wait_idle();

    // Same-cycle set and clear of ACK queues a second ACK without a drop
    do_reset();
    send_req(3'b001);
    send_req(3'b001);
    get_frame(0, f, s1);
    chk("same_ack1", f, 32'hEB900076);
    get_frame(0, f, s2);
    chk("same_ack2", f, 32'hEB900076);
    chk("same_drop", {24'd0, drop_cnt}, 32'd0);
    wait_idle();

    // Reset mid-ERR frame with STAT pending
    do_reset();
    send_req(3'b110);
    tick();
    chk("rstmid_b0", {24'd0, tx_data}, 32'hEB);
    tick();
    chk("rstmid_b1", {24'd0, tx_data}, 32'h90);
    tick();
    chk("rstmid_b2", {24'd0, tx_data}, 32'h04);
    rst = 1'b1;
    tick();
    chk("rstmid_valid", {31'd0, tx_valid}, 32'd0);
    chk("rstmid_outs", {15'd0, busy, frame_done, tx_data, drop_cnt}, 32'd0);
    rst = 1'b0;
    nv = 0;
    nd = 0;
    repeat (40) begin
      tick();
      if (tx_valid) nv++;
      if (frame_done) nd++;
    end
    chk("rstmid_no_frames", 32'(nv), 32'd0);
    chk("rstmid_no_done", 32'(nd), 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
